// File: rtl/montgomery_encode_pkg.sv
// -----------------------------------------------------------------------------
// montgomery_encode_pkg
//   Shared types and helpers for the Montgomery-domain entry converter.
//   - mont_enc_state_t : FSM states of the bit-serial encoder
//   - cnt_width()      : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package montgomery_encode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mont_enc_state_t;

  // The counter walks 2W-1 down to 0, so it needs $clog2(2W) bits.
  // Clamped to at least one bit so a degenerate width still elaborates.
  function automatic int cnt_width(input int data_width);
    int w;
    w = $clog2(2 * data_width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/montgomery_encode_if.sv
// -----------------------------------------------------------------------------
// montgomery_encode_if
//   Request/response bundle of the Montgomery encoder.
//   Request side : in_valid, in_ready, x, modulant
//   Response side: out_valid, out_ready, out
//   master : the agent that issues requests and consumes results
//   slave  : the encoder itself
// -----------------------------------------------------------------------------
interface montgomery_encode_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] modulant;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;

  modport master (
    output in_valid,
    output x,
    output modulant,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  x,
    input  modulant,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out
  );

endinterface

// File: rtl/montgomery_encode_step.sv
// -----------------------------------------------------------------------------
// mod_shift_add_step
//   Combinational single step of a bit-serial modular reducer:
//     o_acc = (2*i_acc + i_bit) mod i_n
//   Requires i_acc < i_n, which keeps 2*i_acc + i_bit below 2*i_n so one
//   conditional subtraction is enough. A zero modulus yields 0.
//   Ports:
//     i_acc  W  running remainder (< i_n)
//     i_bit  1  next dividend bit, MSB first
//     i_n    W  modulus
//     o_acc  W  updated remainder
// -----------------------------------------------------------------------------
module mod_shift_add_step #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic                  i_bit,
  input  logic [DATA_WIDTH-1:0] i_n,
  output logic [DATA_WIDTH-1:0] o_acc
);

  logic [DATA_WIDTH:0] w_t;
  logic [DATA_WIDTH:0] w_n_ext;
  logic [DATA_WIDTH:0] w_diff;

  // t is one bit wider than the operands so the doubled value never wraps.
  assign w_t     = {i_acc, 1'b0} + {{DATA_WIDTH{1'b0}}, i_bit};
  assign w_n_ext = {1'b0, i_n};
  assign w_diff  = w_t - w_n_ext;

  always_comb begin
    o_acc = w_t[DATA_WIDTH-1:0];
    if (i_n == '0) begin
      // Modulus 0 has no meaningful remainder; pin the result to 0 so the
      // encoder output stays defined.
      o_acc = '0;
    end else if (w_t >= w_n_ext) begin
      o_acc = w_diff[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/montgomery_encode.sv
// -----------------------------------------------------------------------------
// montgomery_encode
//   Maps an operand into the Montgomery domain: out = (x * 2^W) mod modulant.
//   The 2W-bit dividend {x, W'b0} is reduced one bit per cycle, MSB first, so
//   a result appears exactly 2W cycles after the request is accepted. Only one
//   request is in flight; a new one is accepted only from IDLE.
//   Ports:
//     clk    1  clock, rising edge
//     reset  1  asynchronous active-high reset, clears all state
//     bus       montgomery_encode_if.slave
//               in_valid/in_ready/x/modulant : request handshake
//               out_valid/out_ready/out      : result handshake
// -----------------------------------------------------------------------------
module montgomery_encode
  import montgomery_encode_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  montgomery_encode_if.slave  bus
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam int SH_W  = 2 * DATA_WIDTH;

  mont_enc_state_t         r_state;
  logic [SH_W-1:0]         r_sh;
  logic [DATA_WIDTH-1:0]   r_n;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out;

  logic [DATA_WIDTH-1:0]   w_acc_next;

  mod_shift_add_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .i_acc (r_acc),
    .i_bit (r_sh[SH_W-1]),
    .i_n   (r_n),
    .o_acc (w_acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_n         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            // Operands are captured here only; the upstream may change them
            // freely afterwards.
            r_sh       <= {bus.x, {DATA_WIDTH{1'b0}}};
            r_n        <= bus.modulant;
            r_acc      <= '0;
            r_cnt      <= CNT_W'(SH_W - 1);
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          r_acc <= w_acc_next;
          r_sh  <= r_sh << 1;
          if (r_cnt == '0) begin
            // Last bit consumed: publish the remainder directly from the
            // step output so out_valid and out rise on the same edge.
            r_out       <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        DONE: begin
          // in_ready stays low on the handshake edge; a new request can
          // only be taken one cycle later from IDLE.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;

endmodule

// File: tb/tb_montgomery_encode.sv
module tb_montgomery_encode;

  localparam int W = 8;

  logic clk;
  logic reset;

  montgomery_encode_if #(.DATA_WIDTH(W)) bus ();

  montgomery_encode #(
    .DATA_WIDTH(W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic for (x * 2^W) mod n; n == 0 gives 0.
  function automatic int ref_encode(input int xv, input int nv);
    if (nv == 0) return 0;
    return (xv * 256) % nv;
  endfunction

  // Montgomery reduction REDC(t) = t * R^-1 mod n, R = r_minus_one + 1,
  // done bit by bit: add n when odd, then halve.
  function automatic int montgomery_reduce(input int t, input int nv, input int r_minus_one);
    int a;
    int bits;
    a = t;
    bits = $clog2(r_minus_one + 1);
    for (int i = 0; i < bits; i++) begin
      if ((a % 2) != 0) a = a + nv;
      a = a / 2;
    end
    if (a >= nv) a = a - nv;
    return a;
  endfunction

  // Scoreboard: expected results queued at each accepted request and
  // checked whenever a result is presented.
  int exp_q[$];

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("model_unexpected_out_valid", 1, 0);
        end else begin
          check("model_out", int'(bus.out), exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_encode(int'(bus.x), int'(bus.modulant)));
      end
    end
  end

  // Present a request and return one cycle after the accepting edge (+1).
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] nv);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) check("send_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.x        = xv;
    bus.modulant = nv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x        = W'($urandom);
    bus.modulant = W'($urandom);
  endtask

  // Count edges from acceptance until out_valid; low counts cycles with
  // in_ready low while busy (including the cycle right after acceptance).
  task automatic wait_result(output int lat, output int low);
    lat = 0;
    low = 0;
    if (!bus.in_ready) low++;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.out_valid && !bus.in_ready) low++;
    end
  endtask

  task automatic txn(input string name, input logic [W-1:0] xv, input logic [W-1:0] nv,
                     input int exp_lit, input bit detail, output logic [W-1:0] res);
    int lat;
    int low;
    send(xv, nv);
    wait_result(lat, low);
    res = bus.out;
    check({name, "_latency"}, lat, 2 * W);
    if (detail) check({name, "_in_ready_low_in_run"}, low, lat);
    if (exp_lit >= 0) check(name, int'(res), exp_lit);
    $display("txn %s x=%0d n=%0d out=%0d latency=%0d", name, xv, nv, res, lat);
    @(posedge clk); #1;
    if (detail) check({name, "_idle_after_handshake"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] held;
    logic [W-1:0] rx;
    logic [W-1:0] rn;
    int lat;
    int low;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.modulant  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out", int'(bus.out), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Pin the bench's own reference functions with hand-computed values.
    check("model_pin_encode", ref_encode(255, 251), 20);
    check("model_pin_reduce", montgomery_reduce(6, 13, 255), 5);

    // Directed vectors with hand-computed results.
    txn("x5_n13",   8'd5,   8'd13,  6,   1'b1, res);
    txn("x255_n251", 8'd255, 8'd251, 20, 1'b1, res);
    txn("x200_n13", 8'd200, 8'd13,  6,   1'b1, res);
    txn("x0_n13",   8'd0,   8'd13,  0,   1'b1, res);
    txn("x77_n1",   8'd77,  8'd1,   0,   1'b1, res);
    txn("x254_n255", 8'd254, 8'd255, 254, 1'b1, res);
    txn("x5_n0",    8'd5,   8'd0,   0,   1'b1, res);

    // Backpressure: result held for 10 cycles while a new request waits.
    bus.out_ready = 1'b0;
    send(8'd200, 8'd13);
    wait_result(lat, low);
    held = bus.out;
    check("bp_result", int'(held), 6);
    bus.in_valid = 1'b1;
    bus.x        = 8'd9;
    bus.modulant = 8'd13;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid_held", int'(bus.out_valid), 1);
      check("bp_out_held", int'(bus.out), int'(held));
      check("bp_in_ready_low", int'(bus.in_ready), 0);
    end
    $display("txn bp_hold x=200 n=13 out=%0d held 10 cycles", held);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    check("bp_release_out_valid", int'(bus.out_valid), 0);
    // The waiting request (x=9, n=13) is taken on the next edge: 9*256 mod 13 = 3.
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat, low);
    check("bp_pending_latency", lat, 2 * W);
    check("bp_pending_result", int'(bus.out), 3);
    $display("txn bp_pending x=9 n=13 out=%0d latency=%0d", bus.out, lat);
    @(posedge clk); #1;

    // Reset mid-run discards the request.
    send(8'd5, 8'd13);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_out_valid", int'(bus.out_valid), 0);
    check("rst_mid_in_ready", int'(bus.in_ready), 1);
    $display("txn reset_mid_run x=5 n=13 discarded");
    reset = 1'b0;
    @(posedge clk); #1;
    txn("x3_n11_after_reset", 8'd3, 8'd11, 9, 1'b1, res);

    // Round trip through Montgomery reduction with random odd moduli.
    for (int i = 0; i < 1000; i++) begin
      rn = W'($urandom_range(0, 127) * 2 + 1);
      rx = W'($urandom_range(0, int'(rn) - 1));
      txn("rand", rx, rn, -1, 1'b0, res);
      check("roundtrip", montgomery_reduce(int'(res), int'(rn), 255), int'(rx));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
